// File: rtl/multi_cycle_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and
// width helpers used by the top level, the iterative unit and the interface.
package alu_defs;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_SLL   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ITER = 1'b1
  } alu_state_t;

  // Width of the iteration counter, clog2(DATA_WIDTH), never below one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == OP_MULTU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/multi_cycle_alu_if.sv
// Execute-stage ALU request/result bundle. Handshake: a request is accepted
// on a rising edge where start_i=1 and busy_o=0; done_o pulses one cycle when results update.
interface multi_cycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  import alu_defs::*;

  logic                  start_i;
  logic [3:0]            alu_operation_i;
  logic [DATA_WIDTH-1:0] a_i;
  logic [DATA_WIDTH-1:0] b_i;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] alu_data_o;
  logic [DATA_WIDTH-1:0] alu_hi_o;
  logic                  zero_o;
  logic                  div_by_zero_o;
  alu_state_t            state_dbg;

  modport master (
    output start_i, alu_operation_i, a_i, b_i,
    input  busy_o, done_o, alu_data_o, alu_hi_o, zero_o, div_by_zero_o, state_dbg
  );

  modport slave (
    input  start_i, alu_operation_i, a_i, b_i,
    output busy_o, done_o, alu_data_o, alu_hi_o, zero_o, div_by_zero_o, state_dbg
  );

endinterface

// File: rtl/multi_cycle_alu_iter_unit.sv
// Iterative MULTU/DIVU datapath: one shared adder/subtractor, a hi/lo shift
// pair, an operand register and a down-counter. hi_next/lo_next are post-step values.
module alu_iter_unit
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  last,
  output logic                  div_active,
  output logic                  divisor_zero,
  output logic [DATA_WIDTH-1:0] hi_next,
  output logic [DATA_WIDTH-1:0] lo_next
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = cnt_width(DATA_WIDTH);

  logic [W-1:0]  hi_q;
  logic [W-1:0]  lo_q;
  logic [W-1:0]  opnd_q;
  logic [CW-1:0] cnt_q;
  logic          div_q;

  logic [W+1:0]  opx;
  logic [W+1:0]  opy;
  logic [W+1:0]  sum;
  logic          borrow;

  // Multiply: hi += (lo[0] ? mcand : 0), then shift {carry,hi,lo} right.
  // Divide: trial-subtract divisor from {rem,next dividend bit}; sign bit is the borrow.
  always_comb begin
    opx = '0;
    opy = '0;
    if (div_q) begin
      opx = {1'b0, hi_q, lo_q[W-1]};
      opy = ~{2'b00, opnd_q};
    end else begin
      opx = {2'b00, hi_q};
      opy = {2'b00, (lo_q[0] ? opnd_q : {W{1'b0}})};
    end
    sum    = opx + opy + {{(W+1){1'b0}}, div_q};
    borrow = sum[W+1];
  end

  always_comb begin
    hi_next = hi_q;
    lo_next = lo_q;
    if (div_q) begin
      hi_next = borrow ? {hi_q[W-2:0], lo_q[W-1]} : sum[W-1:0];
      lo_next = {lo_q[W-2:0], ~borrow};
    end else begin
      hi_next = sum[W:1];
      lo_next = {sum[0], lo_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
      cnt_q  <= CW'(W - 1);
      div_q  <= is_div;
    end else if (step) begin
      hi_q   <= hi_next;
      lo_q   <= lo_next;
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  assign last         = (cnt_q == '0);
  assign div_active   = div_q;
  assign divisor_zero = (opnd_q == '0);

endmodule

// File: rtl/multi_cycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops complete in one cycle,
// MULTU/DIVU iterate DATA_WIDTH cycles through alu_iter_unit. All results registered.
module multi_cycle_alu
  import alu_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multi_cycle_alu_if.slave        bus
);

  localparam int W   = DATA_WIDTH;
  localparam int SHW = cnt_width(DATA_WIDTH);

  alu_state_t   state_q;
  logic         busy_q;
  logic         done_q;
  logic [W-1:0] data_q;
  logic [W-1:0] hi_q;
  logic         zero_q;
  logic         dbz_q;

  logic [W-1:0] sc_result;
  logic         accept;
  logic         iter_load;
  logic         iter_step;
  logic         iter_last;
  logic         iter_div;
  logic         iter_dbz;
  logic [W-1:0] iter_hi;
  logic [W-1:0] iter_lo;

  always_comb begin
    sc_result = '0;
    case (bus.alu_operation_i)
      OP_AND:  sc_result = bus.a_i & bus.b_i;
      OP_OR:   sc_result = bus.a_i | bus.b_i;
      OP_ADD:  sc_result = bus.a_i + bus.b_i;
      OP_SUB:  sc_result = bus.a_i - bus.b_i;
      OP_NOR:  sc_result = ~(bus.a_i | bus.b_i);
      OP_SLT:  sc_result = {{(W-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
      OP_SLL:  sc_result = bus.a_i << bus.b_i[SHW-1:0];
      OP_SRL:  sc_result = bus.a_i >> bus.b_i[SHW-1:0];
      default: sc_result = '0;
    endcase
  end

  assign accept    = (state_q == ST_IDLE) && bus.start_i;
  assign iter_load = accept && is_iter_op(bus.alu_operation_i);
  assign iter_step = (state_q == ST_ITER);

  alu_iter_unit #(
    .DATA_WIDTH (W)
  ) u_iter (
    .clk          (clk),
    .reset        (reset),
    .load         (iter_load),
    .step         (iter_step),
    .is_div       (bus.alu_operation_i == OP_DIVU),
    .a            (bus.a_i),
    .b            (bus.b_i),
    .last         (iter_last),
    .div_active   (iter_div),
    .divisor_zero (iter_dbz),
    .hi_next      (iter_hi),
    .lo_next      (iter_lo)
  );

  // Starts in ST_ITER are dropped, not queued; the last step lands directly in the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            if (is_iter_op(bus.alu_operation_i)) begin
              state_q <= ST_ITER;
              busy_q  <= 1'b1;
            end else begin
              data_q <= sc_result;
              hi_q   <= '0;
              zero_q <= (sc_result == '0);
              done_q <= 1'b1;
            end
          end
        end
        ST_ITER: begin
          if (iter_last) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            data_q  <= iter_lo;
            hi_q    <= iter_hi;
            zero_q  <= (iter_lo == '0);
            if (iter_div) begin
              dbz_q <= iter_dbz;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.alu_data_o    = data_q;
  assign bus.alu_hi_o      = hi_q;
  assign bus.zero_o        = zero_q;
  assign bus.div_by_zero_o = dbz_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_multi_cycle_alu.sv
// Directed bench for multi_cycle_alu at DATA_WIDTH 32 and 8 with hand-computed
// expected values checked by immediate assertions.
module tb_multi_cycle_alu;
  import alu_defs::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  multi_cycle_alu_if #(.DATA_WIDTH(32)) bus32 ();
  multi_cycle_alu_if #(.DATA_WIDTH(8))  bus8 ();

  multi_cycle_alu #(.DATA_WIDTH(32)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  multi_cycle_alu #(.DATA_WIDTH(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sweep vectors: op, a, b, expected result, expected zero
  logic [3:0]  sw_op  [0:8] = '{OP_ADD, OP_SUB, OP_SLT, OP_SLL, OP_NOR, OP_AND, OP_OR, OP_SRL, 4'b0010};
  logic [31:0] sw_a   [0:8] = '{32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'd1, 32'd0,
                                32'hF0F0_F0F0, 32'h0000_000F, 32'h8000_0000, 32'd5};
  logic [31:0] sw_b   [0:8] = '{32'd1, 32'd5, 32'd1, 32'h24, 32'd0,
                                32'hFF00_FF00, 32'h0000_00F0, 32'h0000_001F, 32'd6};
  logic [31:0] sw_exp [0:8] = '{32'd0, 32'hFFFF_FFFE, 32'd1, 32'h10, 32'hFFFF_FFFF,
                                32'hF000_F000, 32'h0000_00FF, 32'd1, 32'd0};
  logic        sw_z   [0:8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: accept an iterative op, scramble operands, wait for done (bounded).
  task automatic run_iter(input bit w8, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output bit busy_ok);
    bit seen;
    seen    = 1'b0;
    busy_ok = 1'b1;
    lat     = 0;
    if (w8) begin
      bus8.start_i = 1'b1; bus8.alu_operation_i = op; bus8.a_i = a[7:0]; bus8.b_i = b[7:0];
    end else begin
      bus32.start_i = 1'b1; bus32.alu_operation_i = op; bus32.a_i = a; bus32.b_i = b;
    end
    tick();
    if (w8) begin
      bus8.start_i = 1'b0; bus8.a_i = 8'($urandom); bus8.b_i = 8'($urandom);
    end else begin
      bus32.start_i = 1'b0; bus32.a_i = $urandom; bus32.b_i = $urandom;
    end
    for (int i = 1; i <= 60 && !seen; i++) begin
      if (!(w8 ? bus8.busy_o : bus32.busy_o)) busy_ok = 1'b0;
      tick();
      lat = i;
      seen = w8 ? bus8.done_o : bus32.done_o;
    end
    if (!seen) lat = -1;
  endtask

  initial begin
    int lat;
    bit busy_ok;
    bit flag;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus32.start_i = 1'b0; bus32.alu_operation_i = '0; bus32.a_i = '0; bus32.b_i = '0;
    bus8.start_i  = 1'b0; bus8.alu_operation_i  = '0; bus8.a_i  = '0; bus8.b_i  = '0;
    tick();
    tick();

    // reset state
    check("rst_data", bus32.alu_data_o, 0);
    check("rst_hi", bus32.alu_hi_o, 0);
    check("rst_zero", bus32.zero_o, 0);
    check("rst_dbz", bus32.div_by_zero_o, 0);
    check("rst_busy", bus32.busy_o, 0);
    check("rst_done", bus32.done_o, 0);
    check("rst_state", bus32.state_dbg, ST_IDLE);
    check("rst8_data", bus8.alu_data_o, 0);
    reset = 1'b0;
    tick();

    // reset mid-MULTU aborts with no done
    bus32.start_i = 1'b1; bus32.alu_operation_i = OP_MULTU; bus32.a_i = 32'd3; bus32.b_i = 32'd5;
    tick();
    bus32.start_i = 1'b0;
    check("mid_busy", bus32.busy_o, 1);
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    check("abort_busy", bus32.busy_o, 0);
    check("abort_data", bus32.alu_data_o, 0);
    check("abort_hi", bus32.alu_hi_o, 0);
    check("abort_state", bus32.state_dbg, ST_IDLE);
    #1 reset = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus32.done_o) flag = 1'b1;
    end
    check("abort_no_done", flag, 0);
    bus32.start_i = 1'b1; bus32.alu_operation_i = OP_ADD; bus32.a_i = 32'd2; bus32.b_i = 32'd3;
    tick();
    bus32.start_i = 1'b0;
    check("add_after_rst", bus32.alu_data_o, 5);
    check("add_after_rst_done", bus32.done_o, 1);

    // single-cycle sweep, back to back
    for (int i = 0; i < 9; i++) begin
      bus32.start_i = 1'b1; bus32.alu_operation_i = sw_op[i]; bus32.a_i = sw_a[i]; bus32.b_i = sw_b[i];
      tick();
      check($sformatf("sweep%0d_data", i), bus32.alu_data_o, sw_exp[i]);
      check($sformatf("sweep%0d_zero", i), bus32.zero_o, sw_z[i]);
      check($sformatf("sweep%0d_hi", i), bus32.alu_hi_o, 0);
      check($sformatf("sweep%0d_done", i), bus32.done_o, 1);
    end
    bus32.start_i = 1'b0;
    tick();
    check("sweep_done_drop", bus32.done_o, 0);

    // MULTU max*max with an ADD held on start while busy
    bus32.start_i = 1'b1; bus32.alu_operation_i = OP_MULTU;
    bus32.a_i = 32'hFFFF_FFFF; bus32.b_i = 32'hFFFF_FFFF;
    tick();
    bus32.alu_operation_i = OP_ADD; bus32.a_i = 32'd7; bus32.b_i = 32'd8;
    busy_ok = 1'b1;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      if (!bus32.busy_o) busy_ok = 1'b0;
      tick();
      if (bus32.done_o) begin
        lat = i;
        break;
      end
    end
    check("mul_latency", lat, 32);
    check("mul_busy_held", busy_ok, 1);
    check("mul_busy_done_cyc", bus32.busy_o, 0);
    check("mul_hi", bus32.alu_hi_o, 32'hFFFF_FFFE);
    check("mul_lo", bus32.alu_data_o, 32'h0000_0001);
    tick();
    bus32.start_i = 1'b0;
    check("add_in_done_cyc", bus32.alu_data_o, 32'd15);
    check("add_in_done_cyc_hi", bus32.alu_hi_o, 0);
    check("add_in_done_cyc_done", bus32.done_o, 1);
    tick();
    check("add_done_pulse", bus32.done_o, 0);

    // DIVU cases
    run_iter(1'b0, OP_DIVU, 32'd100, 32'd7, lat, busy_ok);
    check("div100_lat", lat, 32);
    check("div100_busy", busy_ok, 1);
    check("div100_q", bus32.alu_data_o, 32'd14);
    check("div100_r", bus32.alu_hi_o, 32'd2);
    check("div100_dbz", bus32.div_by_zero_o, 0);
    run_iter(1'b0, OP_DIVU, 32'd9, 32'd0, lat, busy_ok);
    check("div0_lat", lat, 32);
    check("div0_q", bus32.alu_data_o, 32'hFFFF_FFFF);
    check("div0_r", bus32.alu_hi_o, 32'd9);
    check("div0_dbz", bus32.div_by_zero_o, 1);
    bus32.start_i = 1'b1; bus32.alu_operation_i = OP_ADD; bus32.a_i = 32'd1; bus32.b_i = 32'd1;
    tick();
    bus32.start_i = 1'b0;
    check("dbz_hold_data", bus32.alu_data_o, 2);
    check("dbz_hold_flag", bus32.div_by_zero_o, 1);
    run_iter(1'b0, OP_DIVU, 32'd8, 32'd2, lat, busy_ok);
    check("div8_q", bus32.alu_data_o, 32'd4);
    check("div8_r", bus32.alu_hi_o, 0);
    check("div8_dbz", bus32.div_by_zero_o, 0);

    // DATA_WIDTH = 8 instance
    run_iter(1'b1, OP_MULTU, 32'hFF, 32'h02, lat, busy_ok);
    check("w8_mul_lat", lat, 8);
    check("w8_mul_busy", busy_ok, 1);
    check("w8_mul_hi", bus8.alu_hi_o, 8'h01);
    check("w8_mul_lo", bus8.alu_data_o, 8'hFE);
    bus8.start_i = 1'b1; bus8.alu_operation_i = OP_SRL; bus8.a_i = 8'h80; bus8.b_i = 8'hF7;
    tick();
    bus8.start_i = 1'b0;
    check("w8_srl", bus8.alu_data_o, 8'h01);
    check("w8_srl_done", bus8.done_o, 1);
    run_iter(1'b1, OP_DIVU, 32'hFF, 32'h10, lat, busy_ok);
    check("w8_div_lat", lat, 8);
    check("w8_div_q", bus8.alu_data_o, 8'h0F);
    check("w8_div_r", bus8.alu_hi_o, 8'h0F);
    tick();
    check("w8_done_drop", bus8.done_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
